// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: the instruction-memory req/ack bus and the decode-side handshake.
// The fetch stage connects through master and the memory/decode side through slave.
interface instruction_fetch_if;
  logic        imem_req, imem_ack, inst_valid, inst_ready;
  logic        branch, jump, jump_register, halted, halt_out, fault;
  logic [31:0] imem_addr, imem_rdata, inst, pc, pc_plus4, rs_data;
  logic [5:0]  opcode, func;
  modport master (
    output imem_req, imem_addr, inst, inst_valid, opcode, func, pc, pc_plus4, halt_out, fault,
    input  imem_ack, imem_rdata, inst_ready, branch, jump, jump_register, halted, rs_data
  );
  modport slave (
    input  imem_req, imem_addr, inst, inst_valid, opcode, func, pc, pc_plus4, halt_out, fault,
    output imem_ack, imem_rdata, inst_ready, branch, jump, jump_register, halted, rs_data
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage, PC register, req/ack fetch and next-PC selection.
// Define IF_MISALIGN_TRAP_EN to trap misaligned redirects; otherwise low PC bits are masked.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_b,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, inst, pc, pc_plus4, target, next_pc;
  logic take, trap;
  assign pc_plus4 = pc + 32'd4;
  // Priority: JR over J over branch over sequential; halt is handled separately.
  assign target = bus.jump_register ? bus.rs_data
                : bus.jump          ? {pc_plus4[31:28], inst[25:0], 2'b00}
                : bus.branch        ? pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}
                :                     pc_plus4;
  assign take = state == VALID && bus.inst_ready;
`ifdef IF_MISALIGN_TRAP_EN
  logic fault;
  assign next_pc = target;
  assign trap = |target[1:0];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) fault <= 1'b0;
    else if (take && !bus.halted && trap) fault <= 1'b1;
  assign bus.fault = fault;
`else
  assign next_pc = target & ~32'd3;
  assign trap = 1'b0;
  assign bus.fault = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? FETCH
             : state == FETCH ? (bus.imem_ack ? VALID : FETCH)
             : state == VALID ? (!bus.inst_ready ? VALID : (bus.halted || trap) ? HALT : FETCH)
             :                  HALT;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      inst     <= '0;
      pc       <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && bus.imem_ack) begin
        inst <= bus.imem_rdata;
        pc   <= fetch_pc;
      end
      if (take && !bus.halted && !trap) fetch_pc <= next_pc;
    end
  assign bus.imem_req   = state == FETCH;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = state == VALID;
  assign bus.inst       = inst;
  assign bus.pc         = pc;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.opcode     = inst[31:26];
  assign bus.func       = inst[5:0];
  assign bus.halt_out   = state == HALT;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized memory/decode stimulus with a scoreboard of expected
// fetch addresses and presented instructions, computed from next-PC rules.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef struct {logic [31:0] inst; logic br, j, jr, hlt; logic [31:0] rs;} act_t;
  typedef struct {logic [31:0] inst, pc;} ent_t;
  logic clk = 0, rst_b = 0;
  instruction_fetch_if bus();
  instruction_fetch #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0, errors = 0, cyc = 0, last_v = -1;
  logic [31:0] addr_q[$];
  ent_t inst_q[$];
  act_t script[$];
  logic fast = 1, exp_halt = 0, exp_fault = 0, halt_pend = 0, fault_pend = 0;
  logic req_d = 0, valid_d = 0;
  logic [31:0] exp_fetch = RESET_PC, cur_inst = 0, cur_pc = 0, e_cur = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic act_t mk(logic [31:0] inst, logic br, logic j, logic jr, logic hlt, logic [31:0] rs);
    act_t a;
    a.inst = inst; a.br = br; a.j = j; a.jr = jr; a.hlt = hlt; a.rs = rs;
    return a;
  endfunction

  // Reference next-PC model: plain arithmetic on the architectural rules.
  task automatic consume(act_t a);
    logic [31:0] t, off, seq;
    seq = cur_pc + 32'd4;
    off = int'($signed(cur_inst[15:0])) * 4;
    if (a.jr) t = a.rs;
    else if (a.j) t = (seq & 32'hF000_0000) | ({6'd0, cur_inst[25:0]} * 32'd4);
    else if (a.br) t = seq + off;
    else t = seq;
    if (a.hlt) halt_pend = 1;
`ifdef IF_MISALIGN_TRAP_EN
    else if (t % 4 != 0) begin halt_pend = 1; fault_pend = 1; end
`endif
    else begin
      exp_fetch = t & ~32'd3;
      addr_q.push_back(exp_fetch);
    end
  endtask

  task automatic load_directed();
    script.push_back(mk($urandom, 0, 0, 1, 0, 32'h0000_0100));
    script.push_back(mk({6'h04, 10'h0, 16'hFFFF}, 1, 0, 0, 0, 0));
    script.push_back(mk({6'h04, 10'h0, 16'h0003}, 1, 0, 0, 0, 0));
    script.push_back(mk($urandom, 0, 0, 1, 0, 32'h1000_0000));
    script.push_back(mk({6'h03, 26'h000_0040}, 0, 1, 0, 0, 0));
    script.push_back(mk({6'h02, 26'h000_0020}, 1, 1, 0, 0, 0));
    script.push_back(mk($urandom, 0, 0, 1, 0, 32'hFFFF_FFFC));
    script.push_back(mk($urandom, 0, 0, 0, 0, 0));
    script.push_back(mk({6'h04, 10'h0, 16'hFFFE}, 1, 0, 0, 0, 0));
    script.push_back(mk({6'h02, 26'h3FF_FFFF}, 1, 1, 1, 0, 32'h0000_0300));
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    ent_t e;
    if (!rst_b) begin
      req_d = 0; valid_d = 0; last_v = -1;
    end else begin
      if (bus.imem_req && !req_d) begin
        if (addr_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL fetch_unexpected: got request at %h, expected none (cycle %0d)", bus.imem_addr, cyc);
        end else begin
          e_cur = addr_q.pop_front();
          check("fetch_addr", bus.imem_addr, e_cur);
        end
      end else if (bus.imem_req) check("fetch_addr_stable", bus.imem_addr, e_cur);
      if (bus.inst_valid && !valid_d) begin
        if (inst_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL valid_unexpected: got inst_valid, expected none (cycle %0d)", cyc);
        end else begin
          e = inst_q.pop_front();
          check("inst", bus.inst, e.inst);
          check("pc", bus.pc, e.pc);
          check("opcode", 32'(bus.opcode), 32'(e.inst[31:26]));
          check("func", 32'(bus.func), 32'(e.inst[5:0]));
          check("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
          if (fast && last_v >= 0) check("valid_period", 32'(cyc - last_v), 32'd2);
          last_v = cyc;
        end
      end
      check("halt_out", 32'(bus.halt_out), 32'(exp_halt));
      check("fault", 32'(bus.fault), 32'(exp_fault));
      if (exp_halt) begin
        check("halt_req", 32'(bus.imem_req), 32'd0);
        check("halt_valid", 32'(bus.inst_valid), 32'd0);
      end
      req_d = bus.imem_req;
      valid_d = bus.inst_valid;
    end
  end

  initial begin
    int n_cons, delay, rst_phase, halt_cnt;
    bit in_req, done;
    act_t a;
    n_cons = 0; delay = 0; rst_phase = 0; halt_cnt = 0; in_req = 0; done = 0;
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.inst_ready = 0; bus.branch = 0;
    bus.jump = 0; bus.jump_register = 0; bus.halted = 0; bus.rs_data = 0;
    addr_q.push_back(RESET_PC);
    repeat (3) @(posedge clk);
    #1 rst_b = 1;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(posedge clk);
      #1;
      exp_halt = halt_pend;
      exp_fault = fault_pend;
      if (exp_halt) halt_cnt++;
      if (halt_cnt >= 20) done = 1;
      if (rst_phase == 2) begin
        rst_b = 0; bus.imem_ack = 1; bus.inst_ready = 0;
        #1 check("req_drop_on_reset", 32'(bus.imem_req), 32'd0);
        addr_q.delete(); inst_q.delete();
        exp_fetch = RESET_PC;
        addr_q.push_back(RESET_PC);
        in_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1;
        rst_phase = 3;
        script.push_back(mk($urandom, 0, 0, 1, 0, 32'h0000_0202));
        script.push_back(mk($urandom, 0, 1, 0, 1, 0));
        continue;
      end
      bus.imem_ack = 0;
      bus.imem_rdata = $urandom;
      if (bus.imem_req) begin
        if (!in_req) begin
          in_req = 1;
          delay = fast ? 0 : rst_phase == 1 ? 3 : $urandom_range(0, 3);
          if (rst_phase == 1) rst_phase = 2;
        end
        if (delay == 0) begin
          bus.imem_ack = 1;
          if (script.size() != 0) bus.imem_rdata = script[0].inst;
          cur_inst = bus.imem_rdata;
          cur_pc = exp_fetch;
          inst_q.push_back('{cur_inst, cur_pc});
          in_req = 0;
        end else delay--;
      end else bus.imem_ack = $urandom_range(0, 3) == 0;
      bus.inst_ready = 0;
      bus.branch = $urandom_range(0, 1) == 1;
      bus.jump = $urandom_range(0, 1) == 1;
      bus.jump_register = $urandom_range(0, 1) == 1;
      bus.halted = $urandom_range(0, 1) == 1;
      bus.rs_data = $urandom;
      if (bus.inst_valid) begin
        bus.inst_ready = fast || script.size() != 0 || $urandom_range(0, 3) != 0;
        if (bus.inst_ready) begin
          if (script.size() != 0) a = script.pop_front();
          else if (fast) a = mk(0, 0, 0, 0, 0, 0);
          else a = mk(0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 5) == 0, 0, $urandom & ~32'd3);
          bus.branch = a.br; bus.jump = a.j; bus.jump_register = a.jr;
          bus.halted = a.hlt; bus.rs_data = a.rs;
          consume(a);
          n_cons++;
          if (n_cons == 3) load_directed();
          if (n_cons == 5) fast = 0;
          if (n_cons == 300) rst_phase = 1;
        end
      end
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL timeout: got no halt within cycle budget, expected halt_out after scripted halt");
    end
    check("pending_fetches", 32'(addr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-issue MIPS core. It holds the program counter and requests instructions from instruction memory over a req/ack handshake. It presents each instruction, split into `opcode`/`func`, to the decode/control stage. It then consumes the control stage's `branch`, `jump`, `jump_register` and `halted` decisions to select the next PC. The stage stops permanently on `halted` (SYSCALL).

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; word aligned.
- `imem_ack`  in  1  memory has returned `imem_rdata` for the current request.
- `imem_rdata`  in  32  instruction word; valid only with `imem_ack`.
- `inst`  out  32  latched instruction.
- `inst_valid`  out  1  `inst`/`pc` are valid for decode.
- `inst_ready`  in  1  decode/execute consumes the instruction this cycle.
- `opcode`  out  6  `inst[31:26]`.
- `func`  out  6  `inst[5:0]`.
- `pc`  out  32  address of `inst`.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32; feeds the JAL link path.
- `branch`, `jump`, `jump_register`, `halted`  in  1 each  control decisions for `inst`; sampled only when `inst_valid & inst_ready`.
- `rs_data`  in  32  register-file rs value; JR target.
- `halt_out`  out  1  sticky stop indication.
- `fault`  out  1  misaligned redirect trap; tied 0 without the macro.

## Operation
- FSM states: IDLE, FETCH, VALID, HALT.
- **Reset:** state IDLE; `fetch_pc`=RESET_PC; `inst`=0; `pc`=0; `inst_valid`=0; `imem_req`=0; `halt_out`=0; `fault`=0.
- **IDLE:** unconditionally moves to FETCH on the next edge.
- **FETCH:**
  - Drives `imem_req`=1 and `imem_addr`=`fetch_pc`; both are held stable until ack.
  - On an edge with `imem_ack`=1: `inst`←`imem_rdata`, `pc`←`fetch_pc`, go to VALID.
- **VALID:**
  - Drives `inst_valid`=1 and `imem_req`=0; `imem_ack` is ignored.
  - On an edge with `inst_ready`=1, next PC is chosen by this priority:
    1. `halted` → HALT, `halt_out`=1.
    2. `jump_register` → `rs_data`.
    3. `jump` → {`pc_plus4[31:28]`, `inst[25:0]`, 2'b00}.
    4. `branch` → `pc_plus4` + (sign-extended `inst[15:0]` << 2).
    5. Otherwise → `pc_plus4`.
  - Unless halting: `fetch_pc` ← next PC, go to FETCH.
  - Without `inst_ready`, holds all outputs unchanged.
- **HALT:** `imem_req`=0 and `inst_valid`=0 until reset.
- **Arithmetic:** all 32-bit, wrap silently. 32'hFFFF_FFFC sequential → 32'h0000_0000. Branch offsets may wrap below 0.
- **Simultaneous inputs:** `halted` with any redirect → halt wins. `jump`+`branch` both set → jump wins.

## Timing
- Ack to `inst_valid`: 1 cycle (registered).
- Best-case throughput: one instruction per 2 cycles (ack in the first FETCH cycle, `inst_ready` in the first VALID cycle).
- Redirect target is used by the immediately following FETCH; no wrong-path fetch ever issues.
- `opcode`, `func` and `pc_plus4` are combinational from registered `inst`/`pc`.
- Asynchronous reset mid-FETCH drops `imem_req` immediately. Any late `imem_ack` after reset is ignored (state is IDLE).

## Configuration
- `IF_MISALIGN_TRAP_EN` defined:
  - If the selected next PC has `[1:0]`≠0 (reachable only via `rs_data`), go to HALT with `fault`=1 and `halt_out`=1.
  - No fetch is issued.
- Undefined: next PC `[1:0]` is forced to 2'b00; `fault` is constant 0.

## Test plan
- Reset release, memory acks in first FETCH cycle, `inst_ready` held 1 → `imem_addr` sequence 0x0, 0x4, 0x8; `inst_valid` high every 2nd cycle.
- `inst`=BEQ with imm 16'hFFFF at `pc`=0x100, `branch`=1 → next `imem_addr`=0x100; with imm 0x0003 → 0x110.
- JAL `inst[25:0]`=26'h0000040 at `pc`=0x1000_0000 → `imem_addr`=0x1000_0100; `pc_plus4`=0x1000_0004 while valid.
- `halted`=1 together with `jump`=1 → `halt_out`=1, `imem_req` stays 0 for 20 cycles.
- JR with `rs_data`=0x202 → with macro: `fault`=1 and halt; without macro: `imem_addr`=0x200.
- `rst_b` low while `imem_req`=1 and ack delayed 3 cycles → `imem_req` drops same cycle; after release, first address is RESET_PC.
